// File: rtl/bin2bcd_seq_conv.sv
// bin2bcd_seq_conv: sequential shift-add-3 (double-dabble) binary-to-BCD
// converter feeding the 4-digit seven-segment display driver.
// Output packing is {hundreds[1:0], tens[3:0], ones[3:0]}; it relies on
// the 8-bit input never exceeding 255, so the hundreds digit fits in 2 bits.
// Optional build macro BIN2BCD_CONTINUOUS_EN: ignore start and self-start a
// new conversion every time the block is idle, refreshing bcd every 9 cycles.
module bin2bcd_seq_conv #(
  parameter int WIDTH = 8,
  parameter int BCD_W = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int SCR_W = 12 + WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SCR_W-1:0] scr_q, scr_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             done_q, done_d;
  logic             start_eff;
  logic [SCR_W-1:0] scr_corr;
  logic [SCR_W-1:0] scr_shift;

  // Correct a BCD digit so that the following left shift carries correctly.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

`ifdef BIN2BCD_CONTINUOUS_EN
  logic unused_start;
  assign unused_start = start;
  assign start_eff    = 1'b1;
`else
  assign start_eff    = start;
`endif

  // All three digits are tested on their pre-shift values, then the whole
  // scratch word (BCD digits above the remaining binary bits) shifts by one.
  assign scr_corr  = {add3(scr_q[WIDTH+11:WIDTH+8]),
                      add3(scr_q[WIDTH+7:WIDTH+4]),
                      add3(scr_q[WIDTH+3:WIDTH]),
                      scr_q[WIDTH-1:0]};
  assign scr_shift = scr_corr << 1;

  // Next-state logic: load on accepted start, iterate WIDTH shifts, publish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_eff) begin
          scr_d   = {12'b0, bin};
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scr_d = scr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // Hundreds digit is at most 2, so dropping its top two bits is lossless.
          bcd_d   = scr_shift[WIDTH+BCD_W-1:WIDTH];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq_conv.sv
// Testbench for bin2bcd_seq_conv: randomized and directed conversions checked
// against a decimal-arithmetic reference model.
module tb_bin2bcd_seq_conv;

  logic       clk;
  logic       clr;
  logic       start;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [9:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq_conv #(.WIDTH(8), .BCD_W(10)) dut (
    .clk  (clk),
    .clr  (clr),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .bcd  (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits from plain division, packed {H[1:0],T,O}.
  function automatic logic [9:0] ref_bcd(input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    return {h[1:0], t[3:0], o[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse and observe 13 sample points from the accept edge.
  task automatic do_conv(input logic [7:0] v, output logic [9:0] res,
                         output int ndone, output int nbusy, output int lat,
                         output int early, output int overlap);
    logic [9:0] prev;
    prev = bcd; res = bcd; ndone = 0; nbusy = 0; lat = -1; early = 0; overlap = 0;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (busy) nbusy++;
      if (done && busy) overlap++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          res = bcd;
        end
      end
      if (ndone == 0 && bcd !== prev) early++;
      bin = 8'($urandom);
      tick();
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; bin = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({busy, done, bcd} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold: busy=%b done=%b bcd=%h, required 0/0/000", busy, done, bcd);
      end
    end
`ifndef BIN2BCD_CONTINUOUS_EN
    clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({busy, done, bcd} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: busy=%b done=%b bcd=%h, required 0/0/000", i, busy, done, bcd);
      end
    end
`endif
  endtask

  task automatic test_max();
    logic [9:0] res;
    int nd, nb, lat, early, ov;
    do_conv(8'd255, res, nd, nb, lat, early, ov);
    n_checks++;
    if (res !== 10'b10_0101_0101) begin
      n_fail++; $display("FAIL max_bcd: got %h, required 255", res);
    end
    n_checks++;
    if (nb !== 8) begin
      n_fail++; $display("FAIL max_busy_cycles: got %0d, required 8", nb);
    end
    n_checks++;
    if (lat !== 8 || nd !== 1) begin
      n_fail++; $display("FAIL max_done: latency %0d count %0d, required 8 and 1", lat, nd);
    end
    n_checks++;
    if (ov !== 0 || early !== 0) begin
      n_fail++; $display("FAIL max_overlap_early: overlap %0d early %0d, required 0 0", ov, early);
    end
  endtask

  task automatic test_directed();
    int         vals [7] = '{0, 9, 10, 99, 100, 199, 200};
    logic [9:0] exps [7] = '{10'h000, 10'h009, 10'h010, 10'h099, 10'h100, 10'h199, 10'h200};
    logic [9:0] res;
    int nd, nb, lat, early, ov;
    for (int i = 0; i < 7; i++) begin
      do_conv(8'(vals[i]), res, nd, nb, lat, early, ov);
      n_checks++;
      if (res !== exps[i] || nd !== 1) begin
        n_fail++;
        $display("FAIL directed %0d: bcd %h done_count %0d, required %h and 1", vals[i], res, nd, exps[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [9:0] res;
    int nd, nb, lat, early, ov;
    for (int v = 0; v < 256; v++) begin
      do_conv(8'(v), res, nd, nb, lat, early, ov);
      n_checks++;
      if (res !== ref_bcd(v) || nd !== 1 || lat !== 8 || early !== 0 || ov !== 0) begin
        n_fail++;
        $display("FAIL sweep %0d: bcd %h done %0d lat %0d early %0d ov %0d, required %h 1 8 0 0",
                 v, res, nd, lat, early, ov, ref_bcd(v));
      end
    end
  endtask

  task automatic test_ignore_start();
    int nd, lat;
    logic [9:0] res;
    nd = 0; lat = -1; res = 10'h3ff;
    start = 1'b1; bin = 8'd42;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; bin = 8'd77;
    tick();
    start = 1'b0;
    for (int k = 3; k < 20; k++) begin
      if (done) begin
        nd++;
        if (lat < 0) begin lat = k; res = bcd; end
      end
      tick();
    end
    n_checks++;
    if (nd !== 1 || res !== 10'h042 || lat !== 8) begin
      n_fail++;
      $display("FAIL ignore_start: done %0d bcd %h lat %0d, required 1 042 8", nd, res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] v, e;
    int nd, c, last;
    nd = 0; c = 0; last = 0;
    v = 8'($urandom_range(1, 255));
    q.push_back(v);
    start = 1'b1; bin = v;
    tick();
    while (nd < 6 && c < 100) begin
      if (done) begin
        e = q.pop_front();
        n_checks++;
        if (bcd !== ref_bcd(int'(e)) || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b result %0d: bcd %h busy %b, required %h 0", nd, bcd, busy, ref_bcd(int'(e)));
        end
        n_checks++;
        if ((c - last) !== (nd == 0 ? 8 : 9)) begin
          n_fail++;
          $display("FAIL b2b interval %0d: got %0d cycles, required %0d", nd, c - last, nd == 0 ? 8 : 9);
        end
        last = c;
        nd++;
        if (nd == 6) start = 1'b0;
        else begin
          v = 8'($urandom_range(1, 255));
          q.push_back(v);
          bin = v;
        end
      end else begin
        bin = 8'($urandom);
      end
      tick();
      c++;
    end
    start = 1'b0;
    n_checks++;
    if (nd !== 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d dones, required 6", nd);
    end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset_abort();
    logic [9:0] res;
    int nd, nb, lat, early, ov, stray;
    stray = 0;
    start = 1'b1; bin = 8'd123;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #3;
    clr = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bcd} !== 12'h000) begin
      n_fail++;
      $display("FAIL abort_immediate: busy=%b done=%b bcd=%h, required 0/0/000", busy, done, bcd);
    end
    @(posedge clk); #1;
    clr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done || busy || bcd !== 10'h000) stray++;
      tick();
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL abort_no_done: %0d bad cycles, required 0", stray);
    end
    do_conv(8'd123, res, nd, nb, lat, early, ov);
    n_checks++;
    if (res !== 10'h123 || nd !== 1) begin
      n_fail++; $display("FAIL abort_recover: bcd %h done %0d, required 123 1", res, nd);
    end
  endtask

  task automatic test_continuous();
    int nd, c, last, found;
    nd = 0; c = 0; last = 0; found = 0;
    start = 1'b0; bin = 8'd58;
    clr = 1'b1;
    while (nd < 3 && c < 60) begin
      tick();
      c++;
      if (done) begin
        n_checks++;
        if (bcd !== 10'h058 || busy !== 1'b0) begin
          n_fail++; $display("FAIL cont_58 %0d: bcd %h busy %b, required 058 0", nd, bcd, busy);
        end
        n_checks++;
        if ((c - last) !== 9) begin
          n_fail++; $display("FAIL cont_interval %0d: got %0d, required 9", nd, c - last);
        end
        last = c;
        nd++;
      end
    end
    n_checks++;
    if (nd !== 3) begin
      n_fail++; $display("FAIL cont_count: got %0d dones, required 3", nd);
    end
    bin = 8'd201;
    for (int i = 0; i < 18 && found == 0; i++) begin
      tick();
      if (bcd === 10'h201) found = 1;
    end
    n_checks++;
    if (found !== 1) begin
      n_fail++; $display("FAIL cont_201: bcd %h, required 201 within 18 cycles", bcd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; start = 1'b0; bin = 8'd0;
    test_reset();
`ifdef BIN2BCD_CONTINUOUS_EN
    test_continuous();
`else
    test_max();
    test_directed();
    test_sweep();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
